fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream of dual_port_memory and owns its write and read ports. It turns a push/pop interface into RAM write and read transactions using wrapping pointers. It also reports occupancy, full/empty/almost-full and sticky error flags. The top level instantiates fifo_ctrl and dual_port_memory side by side, with ram_* ports wired one-to-one.

---
 rtl/fifo_ptr.sv | 19 +
 rtl/fifo_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: ADDR_WIDTH+1 bit counter, the extra MSB tells full from empty
// when the address bits of the read and write pointers match.
module fifo_ptr #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving the write/read ports of an external dual_port_memory.
// Read data comes straight from the RAM's registered output; pop_valid tracks that latency.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_CNT   = CNT_W'(DEPTH - AF_MARGIN);
    localparam int                STAGES   = 1;

    logic [CNT_W-1:0] wr_ptr, rd_ptr;
    logic             push_acc, pop_acc;
    logic [STAGES:0]  vld_pipe;

    // Flags come only from the registered count, so accept never loops through push/pop.
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_CNT);

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    assign ram_wr_en   = push_acc;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = push_data;
    assign ram_rd_en   = pop_acc;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    fifo_ptr #(.W(CNT_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(CNT_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (push_acc && !pop_acc)
            count <= count + 1'b1;
        else if (pop_acc && !push_acc)
            count <= count - 1'b1;
    end

    // Stage 0 is the accepted pop; the last stage lines up with the RAM read register.
    assign vld_pipe[0] = pop_acc;
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign pop_valid = vld_pipe[STAGES];
    assign pop_data  = ram_rd_data;

    // err_clr wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

endmodule
